pipelined_adder: RTL and testbench

Parametrised, pipelined integer add/subtract unit and the successor to the flat combinational 32-bit adder. The operand width is split into STAGES equal slices. Each pipeline stage adds one slice and passes its carry forward. Produces sum plus NZCV flags behind a valid/ready handshake with full-pipeline backpressure. Sits between the register-file read stage and writeback in the datapath.

---
 rtl/adder_pkg.sv | 34 +++
 rtl/adder_slice.sv | 20 ++
 rtl/pipelined_adder.sv | 158 +++++++++++++++
 tb/tb_pipelined_adder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// The optional ADDER_SATURATE_EN build uses sat_value() in the final stage.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int SAT_MAX_WIDTH = 256;

    // Signed saturation bound for a width-bit word: max positive when sign=0, min negative when sign=1.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_value(input int width, input logic sign);
        logic [SAT_MAX_WIDTH-1:0] val;
        for (int i = 0; i < SAT_MAX_WIDTH; i++) begin
            if (i < width - 1) begin
                val[i] = ~sign;
            end else if (i == width - 1) begin
                val[i] = sign;
            end else begin
                val[i] = 1'b0;
            end
        end
        return val;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder used once per pipeline stage.
// Reports carry-out and the carry into the slice MSB for overflow detection.
module adder_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_slice,
    input  logic [SLICE-1:0] b_slice,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    // Slice sum; the carry into the MSB is recovered from sum = a ^ b ^ carry at that bit.
    always_comb begin
        {cout, sum} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, cin};
        cmsb        = sum[SLICE-1] ^ a_slice[SLICE-1] ^ b_slice[SLICE-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep ripple-sliced add/subtract with NZCV flags and valid/ready backpressure.
// Define ADDER_SATURATE_EN to clamp signed overflow to the saturation bound.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output flags_t           flags
);

    localparam int SLICE = WIDTH / STAGES;

    logic             stall_s;
    logic             accept_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;
    assign accept_s = in_valid && in_ready;

    // Subtraction is A + ~B + 1, so B is inverted and the carry forced high on entry.
    always_comb begin
        case (op)
            OP_SUB: begin
                b_eff_s   = ~B;
                cin_eff_s = 1'b1;
            end
            default: begin
                b_eff_s   = B;
                cin_eff_s = Cin;
            end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SLICE;

        // w holds finished sum bits below the current slice and untouched A bits above it.
        logic [WIDTH-1:0]    w_in_s;
        logic [WIDTH-LO-1:0] b_in_s;
        logic                c_in_s;
        logic                v_in_s;
        logic [SLICE-1:0]    sum_s;
        logic                cout_s;
        logic                cmsb_s;
        logic [WIDTH-1:0]    w_nxt_s;
        logic                valid_r;
        logic [WIDTH-1:0]    w_r;

        if (k == 0) begin : g_src
            assign w_in_s = A;
            assign b_in_s = b_eff_s;
            assign c_in_s = cin_eff_s;
            assign v_in_s = accept_s;
        end else begin : g_src
            assign w_in_s = g_stage[k-1].w_r;
            assign b_in_s = g_stage[k-1].g_mid.b_r;
            assign c_in_s = g_stage[k-1].g_mid.carry_r;
            assign v_in_s = g_stage[k-1].valid_r;
        end

        adder_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a_slice(w_in_s[LO +: SLICE]),
            .b_slice(b_in_s[SLICE-1:0]),
            .cin    (c_in_s),
            .sum    (sum_s),
            .cout   (cout_s),
            .cmsb   (cmsb_s)
        );

        // Splice this stage's slice sum into the travelling word.
        always_comb begin
            w_nxt_s             = w_in_s;
            w_nxt_s[LO +: SLICE] = sum_s;
        end

        if (k < STAGES - 1) begin : g_mid
            localparam int BW = WIDTH - (k + 1) * SLICE;

            logic [BW-1:0] b_r;
            logic          carry_r;
            logic          cmsb_unused_s;

            assign cmsb_unused_s = cmsb_s;

            // Intermediate stage register; the whole pipeline freezes on stall.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_r <= 1'b0;
                    w_r     <= {WIDTH{1'b0}};
                    b_r     <= {BW{1'b0}};
                    carry_r <= 1'b0;
                end else if (!stall_s) begin
                    valid_r <= v_in_s;
                    w_r     <= w_nxt_s;
                    b_r     <= b_in_s[WIDTH-LO-1:SLICE];
                    carry_r <= cout_s;
                end
            end
        end else begin : g_last
            logic [WIDTH-1:0] res_s;
            flags_t           fl_s;
            flags_t           flags_r;

            // Final result and flags; N and Z always reflect the value actually presented.
            always_comb begin
                fl_s.c = cout_s;
                fl_s.v = cout_s ^ cmsb_s;
`ifdef ADDER_SATURATE_EN
                if (fl_s.v) begin
                    res_s = WIDTH'(sat_value(WIDTH, w_in_s[WIDTH-1]));
                end else begin
                    res_s = w_nxt_s;
                end
`else
                res_s = w_nxt_s;
`endif
                fl_s.n = res_s[WIDTH-1];
                fl_s.z = (res_s == {WIDTH{1'b0}});
            end

            // Output register; holds its last value across bubbles and stalls.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_r <= 1'b0;
                    w_r     <= {WIDTH{1'b0}};
                    flags_r <= 4'b0000;
                end else if (!stall_s) begin
                    valid_r <= v_in_s;
                    if (v_in_s) begin
                        w_r     <= res_s;
                        flags_r <= fl_s;
                    end
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_r;
    assign out       = g_stage[STAGES-1].w_r;
    assign flags     = g_stage[STAGES-1].g_last.flags_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: three adder configurations (32/4, 64/8, 8/1) share one stimulus stream.
// Builds with or without ADDER_SATURATE_EN; the reference model follows the same macro.
module tb_pipelined_adder;
    import adder_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
        logic        lat;
        int          acc;
    } exp_t;

    localparam int NW [3] = '{32, 64, 8};
    localparam int NS [3] = '{4, 8, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    op_t         op = OP_ADD;
    logic [63:0] ina = 64'd0;
    logic [63:0] inb = 64'd0;
    logic        cin = 1'b0;
    logic        dir_en = 1'b0;
    logic [31:0] dir_res = 32'd0;
    logic [3:0]  dir_fl = 4'd0;

    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic        all_ready;
    logic        vld_eff;
    logic [63:0] ob [3];
    logic [3:0]  fl [3];
    logic [31:0] o0;
    logic [63:0] o1;
    logic [7:0]  o2;
    flags_t      f0, f1, f2;

    exp_t        q [3][$];
    logic        hold_v [3];
    logic [63:0] hold_o [3];
    logic [3:0]  hold_f [3];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign all_ready = &rdy;
    assign vld_eff   = in_valid && all_ready;
    assign ob[0] = {32'd0, o0};
    assign ob[1] = o1;
    assign ob[2] = {56'd0, o2};
    assign fl[0] = f0;
    assign fl[1] = f1;
    assign fl[2] = f2;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(vld_eff), .in_ready(rdy[0]), .op(op),
        .A(ina[31:0]), .B(inb[31:0]), .Cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
        .out(o0), .flags(f0));

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(vld_eff), .in_ready(rdy[1]), .op(op),
        .A(ina), .B(inb), .Cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
        .out(o1), .flags(f1));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(vld_eff), .in_ready(rdy[2]), .op(op),
        .A(ina[7:0]), .B(inb[7:0]), .Cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
        .out(o2), .flags(f2));

    // Arithmetic reference: exact integer add/subtract, flags from the signed/unsigned meaning.
    function automatic exp_t model(input int w, input logic sub, input logic [63:0] a_i,
                                   input logic [63:0] b_i, input logic c_i);
        exp_t        e;
        logic [63:0] mask, a, b, r;
        logic [64:0] full;
        logic        c, v, sa, sb, sr;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a_i & mask;
        b = b_i & mask;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            c    = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {64'd0, c_i};
            c    = full[w];
        end
        r  = full[63:0] & mask;
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        v  = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
`ifdef ADDER_SATURATE_EN
        if (v) r = sa ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
        e.res = r;
        e.fl  = {r[w-1], (r == 64'd0), c, v};
        e.lat = 1'b0;
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            exp_t e;
            if (hold_v[d] && !reset) begin
                total++;
                if (!ov[d] || ob[d] !== hold_o[d] || fl[d] !== hold_f[d]) begin
                    bad++;
                    $display("FAIL hold d%0d: got v=%0b out=%h fl=%b, want v=1 out=%h fl=%b",
                             d, ov[d], ob[d], fl[d], hold_o[d], hold_f[d]);
                end
            end
            hold_v[d] = ov[d] && !out_ready && !reset;
            hold_o[d] = ob[d];
            hold_f[d] = fl[d];

            if (!reset) begin
                total++;
                if (rdy[d] !== !(ov[d] && !out_ready)) begin
                    bad++;
                    $display("FAIL in_ready d%0d: got %0b want %0b", d, rdy[d], !(ov[d] && !out_ready));
                end
            end

            if (ov[d] === 1'b1 && out_ready) begin
                total++;
                if (q[d].size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out d%0d: got out=%h with no pending op", d, ob[d]);
                end else begin
                    e = q[d].pop_front();
                    if (ob[d] !== e.res || fl[d] !== e.fl) begin
                        bad++;
                        $display("FAIL result d%0d: got out=%h fl=%b want out=%h fl=%b",
                                 d, ob[d], fl[d], e.res, e.fl);
                    end
                    if (e.lat) begin
                        total++;
                        if (cyc - e.acc != NS[d]) begin
                            bad++;
                            $display("FAIL latency d%0d: got %0d want %0d", d, cyc - e.acc, NS[d]);
                        end
                    end
                end
            end

            if (reset) begin
                q[d].delete();
            end else if (vld_eff) begin
                e = model(NW[d], op == OP_SUB, ina, inb, cin);
                if (d == 0 && dir_en) begin
                    e.res = {32'd0, dir_res};
                    e.fl  = dir_fl;
                end
                e.lat = dir_en;
                e.acc = cyc;
                q[d].push_back(e);
            end
        end
    end

    task automatic send(input op_t o, input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic d_en, input logic [31:0] d_res, input logic [3:0] d_fl);
        int n;
        logic ok;
        op = o; ina = a; inb = b; cin = c;
        dir_en = d_en; dir_res = d_res; dir_fl = d_fl;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = all_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%b want 111 within 200 cycles", rdy);
        end
        in_valid = 1'b0;
        dir_en = 1'b0;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'h0000_0000_7FFF_FFFF;
            3: return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        total++;
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d/%0d pending want 0", q[0].size(), q[1].size(), q[2].size());
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) hold_v[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ov[d] !== 1'b0 || ob[d] !== 64'd0 || fl[d] !== 4'd0 || rdy[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_state d%0d: got v=%0b out=%h fl=%b rdy=%0b want 0/0/0/1",
                         d, ov[d], ob[d], fl[d], rdy[d]);
            end
        end
        @(posedge clk);
        #1;

        send(OP_ADD, 64'h0, 64'h0, 1'b0, 1'b1, 32'h0000_0000, 4'b0100);
        send(OP_ADD, 64'hFFFF_FFFE, 64'h4, 1'b1, 1'b1, 32'h0000_0003, 4'b0010);
`ifdef ADDER_SATURATE_EN
        send(OP_ADD, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0001);
        send(OP_SUB, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b1011);
`else
        send(OP_ADD, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
        send(OP_SUB, 64'h8000_0000, 64'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011);
`endif
        send(OP_SUB, 64'h5, 64'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000);
        send(OP_SUB, 64'h7, 64'h5, 1'b1, 1'b1, 32'h0000_0002, 4'b0010);
        send(OP_SUB, 64'h5, 64'h5, 1'b0, 1'b1, 32'h0000_0000, 4'b0110);
        drain();

        // Back-to-back random ADDs with a three-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(OP_ADD, rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 4'd0);
            end
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mixed ADD/SUB traffic under random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send($urandom_range(0, 1) == 0 ? OP_ADD : OP_SUB, rnd_operand(), rnd_operand(),
                         1'($urandom_range(0, 1)), 1'b0, 32'd0, 4'd0);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with ops in flight: nothing stale may emerge afterwards.
        for (int i = 0; i < 3; i++)
            send(OP_ADD, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 32'd0, 4'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (ov[d] !== 1'b0) begin
                    bad++;
                    $display("FAIL post_reset_valid d%0d: got %0b want 0", d, ov[d]);
                end
            end
        end
        @(posedge clk);
        #1;
        send(OP_ADD, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
